// File: rtl/uart_tx_sched_pkg.sv
// Shared state encoding, widths and byte helpers for the UART TX scheduler.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } sched_state_t;

    localparam int CNT_W       = 2;
    localparam int BUSY_TO_DEF = 4;

    // Bytes in a frame: requester 1 may send two, requester 0 always one.
    function automatic logic [CNT_W-1:0] frame_len(input logic owner, input logic len2);
        if (owner && len2) begin
            return CNT_W'(2'd2);
        end else begin
            return CNT_W'(2'd1);
        end
    endfunction

    function automatic logic [7:0] pick_byte(input logic [15:0] payload, input logic [CNT_W-1:0] idx);
        if (idx == CNT_W'(2'd1)) begin
            return payload[15:8];
        end else begin
            return payload[7:0];
        end
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter2.sv
// Two-way round-robin grant; the pointer moves away from the requester just served.
module rr_arbiter2
    import uart_tx_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    input  logic       adv_id,
    output logic       gnt_vld,
    output logic       gnt_id
);

    logic ptr_r;

    // Preferred-requester pointer, updated when a frame retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (adv) begin
            ptr_r <= ~adv_id;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Grant decode: the pointer only matters when both are requesting
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        case (req)
            2'b01: begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end
            2'b10: begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
            2'b11: begin
                gnt_vld = 1'b1;
                gnt_id  = ptr_r;
            end
            default: begin
                gnt_vld = 1'b0;
                gnt_id  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX path between a register-read requester and an ALU-result
// requester, strobing bytes only into an idle transmitter with a single retry.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int BUSY_TO = BUSY_TO_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0,
    input  logic [7:0]  req0_data,
    input  logic        req1,
    input  logic [15:0] req1_data,
    input  logic        req1_len2,
    input  logic        cfg_par_en,
    input  logic        cfg_par_typ,
    input  logic        tx_busy,
    output logic [7:0]  tx_p_data,
    output logic        tx_data_valid,
    output logic        tx_par_en,
    output logic        tx_par_typ,
    output logic        ack0,
    output logic        ack1,
    output logic        frame_err,
    output logic        sched_busy
);

    localparam int TO_W = $clog2(BUSY_TO);

    sched_state_t      state_r;
    logic              owner_r;
    logic [15:0]       payload_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  idx_r;
    logic              retry_r;
    logic [TO_W-1:0]   to_cnt_r;

    logic              gnt_vld_s;
    logic              gnt_id_s;
    logic              grant_s;
    logic              to_hit_s;
    logic              last_byte_s;
    logic              abort_s;
    logic              done_s;
    logic              adv_s;

    rr_arbiter2 u_arb (
        .clk     (CLK),
        .rst_n   (RST),
        .req     ({req1, req0}),
        .adv     (adv_s),
        .adv_id  (owner_r),
        .gnt_vld (gnt_vld_s),
        .gnt_id  (gnt_id_s)
    );

    // Per-cycle decodes; no grant in the ack cycle so a requester still
    // holding its just-acked request is not served twice
    always_comb begin
        to_hit_s    = (to_cnt_r == TO_W'(BUSY_TO - 1));
        last_byte_s = (idx_r == (count_r - CNT_W'(2'd1)));
        abort_s     = (state_r == ST_WAIT_HI) && !tx_busy && to_hit_s && retry_r;
        done_s      = (state_r == ST_WAIT_LO) && !tx_busy && last_byte_s;
        grant_s     = (state_r == ST_IDLE) && gnt_vld_s && !tx_busy && !ack0 && !ack1;
        adv_s       = abort_s || done_s;
    end

    // Scheduler FSM with frame latches, timeout counter and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r       <= ST_IDLE;
            owner_r       <= 1'b0;
            payload_r     <= 16'h0000;
            count_r       <= {CNT_W{1'b0}};
            idx_r         <= {CNT_W{1'b0}};
            retry_r       <= 1'b0;
            to_cnt_r      <= {TO_W{1'b0}};
            tx_p_data     <= 8'h00;
            tx_data_valid <= 1'b0;
            tx_par_en     <= 1'b0;
            tx_par_typ    <= 1'b0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            frame_err     <= 1'b0;
            sched_busy    <= 1'b0;
        end else begin
            tx_data_valid <= 1'b0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            frame_err     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        owner_r       <= gnt_id_s;
                        payload_r     <= gnt_id_s ? req1_data : {8'h00, req0_data};
                        count_r       <= frame_len(gnt_id_s, req1_len2);
                        idx_r         <= {CNT_W{1'b0}};
                        retry_r       <= 1'b0;
                        tx_par_en     <= cfg_par_en;
                        tx_par_typ    <= cfg_par_typ;
                        tx_p_data     <= gnt_id_s ? req1_data[7:0] : req0_data;
                        tx_data_valid <= 1'b1;
                        sched_busy    <= 1'b1;
                        state_r       <= ST_SEND;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    to_cnt_r <= {TO_W{1'b0}};
                    state_r  <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (tx_busy) begin
                        state_r <= ST_WAIT_LO;
                    end else if (to_hit_s) begin
                        if (retry_r) begin
                            ack0       <= ~owner_r;
                            ack1       <= owner_r;
                            frame_err  <= 1'b1;
                            sched_busy <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            // Transmitter missed the strobe: present the same byte once more
                            retry_r       <= 1'b1;
                            tx_data_valid <= 1'b1;
                            state_r       <= ST_SEND;
                        end
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1'b1);
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (last_byte_s) begin
                            ack0       <= ~owner_r;
                            ack1       <= owner_r;
                            sched_busy <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            idx_r         <= idx_r + CNT_W'(2'd1);
                            retry_r       <= 1'b0;
                            tx_p_data     <= pick_byte(payload_r, idx_r + CNT_W'(2'd1));
                            tx_data_valid <= 1'b1;
                            state_r       <= ST_SEND;
                        end
                    end else begin
                        state_r <= ST_WAIT_LO;
                    end
                end
                default: begin
                    sched_busy <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: expected strobes/acks are queued with
// each request and a monitor thread pops them as the DUT presents outputs.
module tb_uart_tx_scheduler;

    localparam int BUSY_TO  = 4;
    localparam int BUSY_LEN = 11;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req0;
    logic [7:0]  req0_data;
    logic        req1;
    logic [15:0] req1_data;
    logic        req1_len2;
    logic        cfg_par_en;
    logic        cfg_par_typ;
    logic        tx_busy;
    logic [7:0]  tx_p_data;
    logic        tx_data_valid;
    logic        tx_par_en;
    logic        tx_par_typ;
    logic        ack0;
    logic        ack1;
    logic        frame_err;
    logic        sched_busy;

    typedef struct {
        bit         is_ack;
        logic [7:0] data;
        logic       id;
        logic       err;
        logic       pen;
        logic       ptyp;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_strobe = 0;
    int   tx_mode  = 0;    // 0 accept, 1 ignore first strobe, 2 never accept
    int   ign_base = 0;
    int   strobe_no = 0;
    int   busy_left = 0;

    uart_tx_scheduler #(.BUSY_TO(BUSY_TO)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req0          (req0),
        .req0_data     (req0_data),
        .req1          (req1),
        .req1_data     (req1_data),
        .req1_len2     (req1_len2),
        .cfg_par_en    (cfg_par_en),
        .cfg_par_typ   (cfg_par_typ),
        .tx_busy       (tx_busy),
        .tx_p_data     (tx_p_data),
        .tx_data_valid (tx_data_valid),
        .tx_par_en     (tx_par_en),
        .tx_par_typ    (tx_par_typ),
        .ack0          (ack0),
        .ack1          (ack1),
        .frame_err     (frame_err),
        .sched_busy    (sched_busy)
    );

    always #5 CLK = ~CLK;

    // Transmitter model: busy rises the cycle after an accepted strobe, lasts BUSY_LEN cycles
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_busy   <= 1'b0;
            busy_left <= 0;
        end else begin
            if (tx_data_valid) begin
                strobe_no <= strobe_no + 1;
                if (tx_mode == 0 || (tx_mode == 1 && strobe_no != ign_base)) begin
                    tx_busy   <= 1'b1;
                    busy_left <= BUSY_LEN;
                end
            end else if (busy_left > 1) begin
                busy_left <= busy_left - 1;
            end else if (busy_left == 1) begin
                busy_left <= 0;
                tx_busy   <= 1'b0;
            end
        end
    end

    function automatic void push_s(input logic [7:0] d, input logic pen, input logic ptyp, input int gap);
        exp_t e;
        e.is_ack = 1'b0; e.data = d; e.id = 1'b0; e.err = 1'b0;
        e.pen = pen; e.ptyp = ptyp; e.gap = gap;
        exp_q.push_back(e);
    endfunction

    function automatic void push_a(input logic id, input logic err, input logic pen, input logic ptyp, input int gap);
        exp_t e;
        e.is_ack = 1'b1; e.data = 8'h00; e.id = id; e.err = err;
        e.pen = pen; e.ptyp = ptyp; e.gap = gap;
        exp_q.push_back(e);
    endfunction

    task automatic check_strobe();
        exp_t e;
        bit   ok;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL strobe_unexpected: got data=%h at cycle %0d, required no strobe", tx_p_data, cyc);
        end else begin
            e  = exp_q.pop_front();
            ok = !e.is_ack && (tx_p_data == e.data) && (tx_par_en == e.pen) && (tx_par_typ == e.ptyp)
                 && !tx_busy && (e.gap == 0 || (cyc - last_strobe) == e.gap);
            if (ok) n_pass++;
            else $display("FAIL strobe: got data=%h pen=%b typ=%b busy=%b gap=%0d, required is_ack=%b data=%h pen=%b typ=%b busy=0 gap=%0d",
                          tx_p_data, tx_par_en, tx_par_typ, tx_busy, cyc - last_strobe,
                          e.is_ack, e.data, e.pen, e.ptyp, e.gap);
        end
        last_strobe = cyc;
    endtask

    task automatic check_ack();
        exp_t e;
        bit   ok;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL ack_unexpected: got ack0=%b ack1=%b frame_err=%b at cycle %0d, required none", ack0, ack1, frame_err, cyc);
        end else begin
            e  = exp_q.pop_front();
            ok = e.is_ack && (ack1 == e.id) && (ack0 == !e.id) && (frame_err == e.err)
                 && (tx_par_en == e.pen) && (tx_par_typ == e.ptyp) && !sched_busy
                 && (e.gap == 0 || (cyc - last_strobe) == e.gap);
            if (ok) n_pass++;
            else $display("FAIL ack: got ack0=%b ack1=%b err=%b pen=%b typ=%b sbusy=%b gap=%0d, required is_ack=%b id=%b err=%b pen=%b typ=%b sbusy=0 gap=%0d",
                          ack0, ack1, frame_err, tx_par_en, tx_par_typ, sched_busy, cyc - last_strobe,
                          e.is_ack, e.id, e.err, e.pen, e.ptyp, e.gap);
        end
    endtask

    task automatic check_reset(input string nm);
        logic [15:0] outs;
        outs = {tx_p_data, tx_data_valid, tx_par_en, tx_par_typ, ack0, ack1, frame_err, sched_busy};
        n_checks++;
        if (outs == 16'h0000) n_pass++;
        else $display("FAIL %s: got outputs=%h, required 0000", nm, outs);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge CLK);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL %s_drain: got %0d pending expectations, required 0", nm, exp_q.size());
        repeat (2) @(negedge CLK);
    endtask

    task automatic run_req0(input logic [7:0] d);
        bit got;
        @(negedge CLK);
        req0_data = d;
        req0      = 1'b1;
        got       = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge CLK);
            got = ack0;
        end
        req0 = 1'b0;
        if (!got) begin
            n_checks++;
            $display("FAIL req0_ack_timeout: got no ack0, required one within 400 cycles");
        end
    endtask

    task automatic run_req1(input logic [15:0] d, input logic len2);
        bit got;
        @(negedge CLK);
        req1_data = d;
        req1_len2 = len2;
        req1      = 1'b1;
        got       = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge CLK);
            got = ack1;
        end
        req1 = 1'b0;
        if (!got) begin
            n_checks++;
            $display("FAIL req1_ack_timeout: got no ack1, required one within 400 cycles");
        end
    endtask

    initial begin
        bit got;
        RST = 1'b0; req0 = 1'b0; req0_data = 8'h00; req1 = 1'b0; req1_data = 16'h0000;
        req1_len2 = 1'b0; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;

        // Monitor: pops the scoreboard whenever the DUT strobes or acks
        fork
            forever begin
                @(negedge CLK);
                cyc++;
                if (RST) begin
                    if (tx_data_valid) check_strobe();
                    else if (ack0 || ack1 || frame_err) check_ack();
                end
            end
        join_none

        repeat (3) @(negedge CLK);
        check_reset("reset_state");
        RST = 1'b1;

        // Single byte from requester 0, parity on/even
        cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
        push_s(8'hA5, 1'b1, 1'b0, 0);
        push_a(1'b0, 1'b0, 1'b1, 1'b0, 13);
        run_req0(8'hA5);
        drain("t1");

        // Two-byte frame, LSB first; cfg and data disturbed mid-frame
        cfg_par_en = 1'b0; cfg_par_typ = 1'b1;
        push_s(8'h34, 1'b0, 1'b1, 0);
        push_s(8'h12, 1'b0, 1'b1, 13);
        push_a(1'b1, 1'b0, 1'b0, 1'b1, 13);
        fork
            run_req1(16'h1234, 1'b1);
            begin
                repeat (3) @(negedge CLK);
                cfg_par_en = 1'b1; cfg_par_typ = 1'b0; req1_data = 16'hFFFF;
            end
        join
        drain("t2");

        // Both requesting from reset: alternate 0,1,0,1
        RST = 1'b0;
        @(negedge CLK);
        check_reset("reset_state2");
        RST = 1'b1;
        cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
        push_s(8'h11, 1'b1, 1'b1, 0);  push_a(1'b0, 1'b0, 1'b1, 1'b1, 13);
        push_s(8'h22, 1'b1, 1'b1, 15); push_a(1'b1, 1'b0, 1'b1, 1'b1, 13);
        push_s(8'h33, 1'b1, 1'b1, 15); push_a(1'b0, 1'b0, 1'b1, 1'b1, 13);
        push_s(8'h44, 1'b1, 1'b1, 15); push_a(1'b1, 1'b0, 1'b1, 1'b1, 13);
        fork
            begin run_req0(8'h11); run_req0(8'h33); end
            begin run_req1(16'hEE22, 1'b0); run_req1(16'h7744, 1'b0); end
        join
        drain("t3");

        // First strobe ignored, retry accepted
        tx_mode = 1; ign_base = strobe_no;
        cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
        push_s(8'hC3, 1'b1, 1'b0, 0);
        push_s(8'hC3, 1'b1, 1'b0, BUSY_TO + 1);
        push_a(1'b1, 1'b0, 1'b1, 1'b0, 13);
        run_req1(16'h00C3, 1'b0);
        drain("t4");

        // Transmitter never accepts: abort with frame_err
        tx_mode = 2;
        cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
        push_s(8'h3C, 1'b0, 1'b0, 0);
        push_s(8'h3C, 1'b0, 1'b0, BUSY_TO + 1);
        push_a(1'b0, 1'b1, 1'b0, 1'b0, BUSY_TO + 1);
        run_req0(8'h3C);
        drain("t5");
        tx_mode = 0;

        // Reset during WAIT_LO of byte 0 of a 2-byte frame
        cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
        push_s(8'hEF, 1'b1, 1'b1, 0);
        @(negedge CLK);
        req1_data = 16'hBEEF; req1_len2 = 1'b1; req1 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            got = tx_data_valid;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL t6_strobe_timeout: got no strobe, required one within 50 cycles");
        end
        repeat (4) @(negedge CLK);
        n_checks++;
        if (sched_busy && tx_busy) n_pass++;
        else $display("FAIL t6_mid_frame: got sched_busy=%b tx_busy=%b, required 1 1", sched_busy, tx_busy);
        RST = 1'b0; req1 = 1'b0;
        #1;
        check_reset("reset_async");
        @(negedge CLK);
        check_reset("reset_next");
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        cfg_par_en = 1'b0; cfg_par_typ = 1'b1;
        push_s(8'h5A, 1'b0, 1'b1, 0);
        push_a(1'b0, 1'b0, 1'b0, 1'b1, 13);
        run_req0(8'h5A);
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
